instr_encoder: RTL and testbench

- Encodes MIPS-subset instruction requests (kind + register/immediate fields) into 32-bit instruction words and writes them sequentially into instruction memory.
- This is the inverse of the pipeline's instruction decoder. It serves as the on-chip program loader that fills imem before the core is released.
- Requests enter through a valid/ready handshake and pass through a small FIFO. A write port drains the FIFO into imem under memory back-pressure.

---
 rtl/instr_pkg.sv | 50 +++++
 rtl/instr_encoder_if.sv | 34 +++
 rtl/instr_encoder_sync_fifo.sv | 50 +++++
 rtl/instr_encoder.sv | 138 +++++++++++++
 tb/tb_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_pkg
// Description : MIPS-subset kind codes, opcodes, functs and encoder states.
//               Shared by the instruction encoder and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

    localparam logic [3:0] KIND_ADD  = 4'd0;
    localparam logic [3:0] KIND_SUB  = 4'd1;
    localparam logic [3:0] KIND_AND  = 4'd2;
    localparam logic [3:0] KIND_OR   = 4'd3;
    localparam logic [3:0] KIND_NOR  = 4'd4;
    localparam logic [3:0] KIND_SLT  = 4'd5;
    localparam logic [3:0] KIND_JR   = 4'd6;
    localparam logic [3:0] KIND_ADDI = 4'd7;
    localparam logic [3:0] KIND_SLTI = 4'd8;
    localparam logic [3:0] KIND_LW   = 4'd9;
    localparam logic [3:0] KIND_SW   = 4'd10;
    localparam logic [3:0] KIND_BEQ  = 4'd11;
    localparam logic [3:0] KIND_J    = 4'd12;
    localparam logic [3:0] KIND_JAL  = 4'd13;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_if
// Description : Request handshake and imem write port of the encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [DWIDTH-1:0] in_imm;
    logic [27:0]       in_target;
    logic              imem_we;
    logic [AWIDTH-1:0] imem_addr;
    logic [DWIDTH-1:0] imem_wdata;
    logic              mem_ready;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, mem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, mem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, power-of-two depth, show-ahead head word.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_push,
    input  wire logic [DWIDTH-1:0] i_push_data,
    input  wire logic              i_pop,
    output logic      [DWIDTH-1:0] o_pop_data,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int c_aw = $clog2(DEPTH);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]     r_wr_ptr;
    logic [c_aw:0]     r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    // Extra pointer bit tells full from empty when the indices match
    assign o_full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                        (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
    end
endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Encodes MIPS-subset requests and loads them into imem.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_pkg::*;
#(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 12,
    parameter int                DEPTH    = 4,
    parameter logic [DWIDTH-1:0] END_WORD = '0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic [AWIDTH-1:0] base_addr,
    input  wire logic              flush,
    instr_encoder_if.slave         bus,
    output logic      [15:0]       words_written,
    output logic                   err,
    output logic      [7:0]        err_cnt,
    output logic                   done
);
    enc_state_t        r_state, w_state_next;
    logic [AWIDTH-1:0] r_addr;
    logic [15:0]       r_count;
    logic              r_err;
    logic [7:0]        r_err_cnt;
    logic [31:0]       w_word;
    logic              w_legal, w_imm_ok, w_accept, w_push, w_pop;
    logic              w_we, w_term, w_start_ok, w_full, w_empty;
    logic [DWIDTH-1:0] w_head;

    // Immediate fits 16 bits signed when everything above bit 15 is sign
    assign w_imm_ok   = (&bus.in_imm[DWIDTH-1:15]) || !(|bus.in_imm[DWIDTH-1:15]);
    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_push     = w_accept && w_legal;
    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);

    always_comb begin
        w_word  = 32'd0;
        w_legal = 1'b1;
        case (bus.in_kind)
            KIND_ADD:  w_word = {OPC_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FUNCT_ADD};
            KIND_SUB:  w_word = {OPC_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FUNCT_SUB};
            KIND_AND:  w_word = {OPC_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FUNCT_AND};
            KIND_OR:   w_word = {OPC_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FUNCT_OR};
            KIND_NOR:  w_word = {OPC_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FUNCT_NOR};
            KIND_SLT:  w_word = {OPC_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FUNCT_SLT};
            KIND_JR:   w_word = {OPC_RTYPE, bus.in_rs, 15'd0, FUNCT_JR};
            KIND_ADDI: begin w_word = {OPC_ADDI, bus.in_rs, bus.in_rt, bus.in_imm[15:0]}; w_legal = w_imm_ok; end
            KIND_SLTI: begin w_word = {OPC_SLTI, bus.in_rs, bus.in_rt, bus.in_imm[15:0]}; w_legal = w_imm_ok; end
            KIND_LW:   begin w_word = {OPC_LW,   bus.in_rs, bus.in_rt, bus.in_imm[15:0]}; w_legal = w_imm_ok; end
            KIND_SW:   begin w_word = {OPC_SW,   bus.in_rs, bus.in_rt, bus.in_imm[15:0]}; w_legal = w_imm_ok; end
            KIND_BEQ:  begin w_word = {OPC_BEQ,  bus.in_rs, bus.in_rt, bus.in_imm[15:0]}; w_legal = w_imm_ok; end
            KIND_J:    begin w_word = {OPC_J,   bus.in_target[27:2]}; w_legal = (bus.in_target[1:0] == 2'b00); end
            KIND_JAL:  begin w_word = {OPC_JAL, bus.in_target[27:2]}; w_legal = (bus.in_target[1:0] == 2'b00); end
            default:   w_legal = 1'b0;
        endcase
    end

    sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (DWIDTH'(w_word)),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_we         = 1'b0;
        w_term       = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN: begin
                w_pop = !w_empty && bus.mem_ready;
                w_we  = w_pop;
                if (flush) w_state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Queued words go first; the terminator follows an empty FIFO
                if (!w_empty) begin
                    w_pop = bus.mem_ready;
                    w_we  = bus.mem_ready;
                end else if (bus.mem_ready) begin
                    w_we         = 1'b1;
                    w_term       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: if (start) w_state_next = ST_RUN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_start_ok) begin
                r_addr  <= base_addr & ~AWIDTH'(3);
                r_count <= '0;
            end else if (w_we) begin
                r_addr  <= r_addr + AWIDTH'(4);
                r_count <= r_count + 16'd1;
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign bus.in_ready   = (r_state == ST_RUN) && !w_full;
    assign bus.imem_we    = w_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = w_we ? (w_term ? END_WORD : w_head) : '0;
    assign words_written  = r_count;
    assign err            = r_err;
    assign err_cnt        = r_err_cnt;
    assign done           = (r_state == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed bench for instr_encoder with a write-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
    import instr_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [11:0] base_addr;
    logic [15:0] words_written;
    logic        err, done;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [11:0] m_addr;
    logic [15:0] m_cnt;
    logic        m_err;
    logic [7:0]  m_errcnt;

    instr_encoder_if #(.DWIDTH(32), .AWIDTH(12)) bus ();

    instr_encoder #(.DWIDTH(32), .AWIDTH(12), .DEPTH(4), .END_WORD(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .flush         (flush),
        .bus           (bus),
        .words_written (words_written),
        .err           (err),
        .err_cnt       (err_cnt),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Field packing by arithmetic; returns 0 when the request must be rejected
    function automatic bit model_enc(input int kind, input int rs, input int rt, input int rd,
                                     input int imm, input int tgt, output logic [31:0] w);
        int funct_tab[7];
        int opc_tab[7];
        funct_tab = '{32, 34, 36, 37, 39, 42, 8};
        opc_tab   = '{8, 10, 35, 43, 4, 2, 3};
        w = 32'd0;
        if (kind <= 5) begin
            w = (rs << 21) | (rt << 16) | (rd << 11) | funct_tab[kind];
            return 1'b1;
        end else if (kind == 6) begin
            w = (rs << 21) | funct_tab[6];
            return 1'b1;
        end else if (kind <= 11) begin
            if (imm < -32768 || imm > 32767) return 1'b0;
            w = (opc_tab[kind-7] << 26) | (rs << 21) | (rt << 16) | (imm & 32'hFFFF);
            return 1'b1;
        end else if (kind <= 13) begin
            if (tgt % 4 != 0) return 1'b0;
            w = (opc_tab[kind-7] << 26) | (tgt / 4);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_addr = 12'h0; m_cnt = 16'h0; m_err = 1'b0; m_errcnt = 8'h0;
    endtask

    task automatic send(input int kind, input int rs, input int rt, input int rd,
                        input int imm, input int tgt);
        int          n;
        logic [31:0] w;
        n = 0;
        bus.in_valid = 1'b1; bus.in_kind = 4'(kind);
        bus.in_rs = 5'(rs); bus.in_rt = 5'(rt); bus.in_rd = 5'(rd);
        bus.in_imm = imm; bus.in_target = 28'(tgt);
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin n++; @(negedge clk); end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 (kind %0d)", kind);
            step(1);
            bus.in_valid = 1'b0;
            return;
        end
        step(1);
        bus.in_valid = 1'b0;
        if (model_enc(kind, rs, rt, rd, imm, tgt, w)) exp_q.push_back(w);
        else begin
            m_err = 1'b1;
            if (m_errcnt != 8'hFF) m_errcnt++;
        end
    endtask

    task automatic do_start(input logic [11:0] a);
        start = 1'b1; base_addr = a;
        step(1);
        start = 1'b0;
        m_addr = a & 12'hFFC; m_cnt = 16'h0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        exp_q.push_back(32'h0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 100) begin n++; @(negedge clk); end
        chk("done_reached", {31'd0, done}, 32'd1);
        step(1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_imem_we"}, {31'd0, bus.imem_we}, 32'd0);
        chk({tag, "_imem_addr"}, {20'd0, bus.imem_addr}, 32'd0);
        chk({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
        chk({tag, "_words_written"}, {16'd0, words_written}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    // Every cycle: counters against the model, each write against the expected order
    always @(negedge clk) begin
        if (!rst) begin
            chk("words_written", {16'd0, words_written}, {16'd0, m_cnt});
            chk("err_state", {23'd0, err, err_cnt}, {23'd0, m_err, m_errcnt});
            if (bus.imem_we) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: addr %h data %h, no write expected",
                             bus.imem_addr, bus.imem_wdata);
                end else begin
                    chk("write_data", bus.imem_wdata, exp_q.pop_front());
                    chk("write_addr", {20'd0, bus.imem_addr}, {20'd0, m_addr});
                end
                m_addr = m_addr + 12'd4;
                m_cnt  = m_cnt + 16'd1;
            end
        end
    end

    initial begin
        logic [31:0] w;
        rst = 1'b1; start = 1'b0; flush = 1'b0; base_addr = 12'h0;
        bus.in_valid = 1'b0; bus.in_kind = 4'd0; bus.in_rs = 5'd0; bus.in_rt = 5'd0;
        bus.in_rd = 5'd0; bus.in_imm = 32'd0; bus.in_target = 28'd0; bus.mem_ready = 1'b0;
        model_reset();
        step(2);
        @(negedge clk);
        chk_all_zero("reset");
        step(1);
        rst = 1'b0;

        void'(model_enc(0, 1, 2, 3, 0, 0, w));        chk("model_add", w, 32'h00221820);
        void'(model_enc(7, 0, 8, 0, -1, 0, w));       chk("model_addi", w, 32'h2008FFFF);
        void'(model_enc(9, 29, 9, 0, 4, 0, w));       chk("model_lw", w, 32'h8FA90004);
        void'(model_enc(13, 0, 0, 0, 0, 'h100, w));   chk("model_jal", w, 32'h0C000040);

        // First word: one cycle after accept
        bus.mem_ready = 1'b1;
        do_start(12'h040);
        send(0, 1, 2, 3, 0, 0);
        @(negedge clk);
        chk("first_we", {31'd0, bus.imem_we}, 32'd1);
        chk("first_addr", {20'd0, bus.imem_addr}, 32'h040);
        chk("first_wdata", bus.imem_wdata, 32'h00221820);
        @(negedge clk);
        chk("first_count", {16'd0, words_written}, 32'd1);
        step(1);
        do_flush();
        wait_done();

        do_start(12'h040);
        send(7, 0, 8, 0, -1, 0);
        send(9, 29, 9, 0, 4, 0);
        send(13, 0, 0, 0, 0, 'h100);
        send(12, 0, 0, 0, 0, 'h102);
        step(3);
        @(negedge clk);
        chk("j_reject_err", {31'd0, err}, 32'd1);
        chk("j_reject_cnt", {24'd0, err_cnt}, 32'd1);
        step(1);

        // Back-pressure: four fill the FIFO, fifth waits for the drain
        bus.mem_ready = 1'b0;
        send(1, 4, 5, 6, 0, 0);
        send(2, 7, 8, 9, 0, 0);
        send(3, 10, 11, 12, 0, 0);
        send(4, 13, 14, 15, 0, 0);
        @(negedge clk);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("held_imem_we", {31'd0, bus.imem_we}, 32'd0);
        step(1);
        fork
            send(5, 16, 17, 18, 0, 0);
            begin step(2); bus.mem_ready = 1'b1; end
        join
        step(6);
        chk("drain_empty", exp_q.size(), 32'd0);

        send(6, 31, 0, 0, 0, 0);
        send(8, 3, 4, 0, -32768, 0);
        send(10, 29, 2, 0, 32767, 0);
        send(11, 1, 2, 0, -3, 0);
        send(7, 1, 1, 0, 32768, 0);
        send(14, 0, 0, 0, 0, 0);
        step(6);
        do_flush();
        wait_done();

        // Address wrap with entries queued before the flush
        do_start(12'hFFE);
        bus.mem_ready = 1'b0;
        send(0, 2, 3, 4, 0, 0);
        send(12, 0, 0, 0, 0, 'h0FFFFFC);
        do_flush();
        step(2);
        @(negedge clk);
        chk("flush_wait_done", {31'd0, done}, 32'd0);
        step(1);
        bus.mem_ready = 1'b1;
        wait_done();
        @(negedge clk);
        chk("flush_count", {16'd0, words_written}, 32'd3);
        chk("flush_addr_after", {20'd0, bus.imem_addr}, 32'h008);
        step(1);

        // Reset in the middle of FLUSH
        do_start(12'h100);
        bus.mem_ready = 1'b0;
        send(0, 1, 1, 1, 0, 0);
        send(1, 2, 2, 2, 0, 0);
        do_flush();
        step(1);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk_all_zero("midreset");
        step(1);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        do_flush();
        exp_q.delete();
        step(2);
        @(negedge clk);
        chk("idle_flush_ignored", {30'd0, done, bus.imem_we}, 32'd0);
        chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step(1);
        do_start(12'h200);
        send(5, 9, 10, 11, 0, 0);
        step(4);
        chk("final_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
